// File: rtl/hazard_sb.sv
// hazard_sb: per-register latency scoreboard driving pipeline stalls and the EX bubble.
// Optional HAZARD_PERF_EN adds a data-hazard stall-cycle counter on perf_hz_cnt.
module hazard_sb #(
   parameter int NREG = 32,
   parameter int LAT_MAX = 7,
   localparam int RW = $clog2(NREG),
   localparam int CW = $clog2(LAT_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic          id_rs1_used,
   input  logic          id_rs2_used,
   input  logic [RW-1:0] id_rd,
   input  logic          id_wr,
   input  logic [CW-1:0] id_lat,
   input  logic          flush,
   input  logic          b_rd_i,
   input  logic          b_rd,
   input  logic          b_wr,
   output logic          stall_if,
   output logic          stall_pd,
   output logic          stall_id,
   output logic          stall_ex,
   output logic          stall_mem,
   output logic          bubble_ex,
   output logic [31:0]   perf_hz_cnt
);
   localparam logic [CW-1:0] LMAX = CW'(LAT_MAX);
   logic [CW-1:0] sb_q [NREG];
   logic [CW-1:0] sb_d [NREG];
   logic [CW-1:0] lat_c;
   logic stall_all, raw, waw, hz, issue;
   assign stall_all = !rst_n | b_rd_i | b_rd | b_wr;
   assign lat_c = (id_lat > LMAX) ? LMAX : id_lat;
   assign raw = id_valid & ((id_rs1_used & (id_rs1 != '0) & (sb_q[id_rs1] != '0))
                          | (id_rs2_used & (id_rs2 != '0) & (sb_q[id_rs2] != '0)));
   assign waw = id_valid & id_wr & (id_rd != '0) & (sb_q[id_rd] > lat_c);
   assign hz = (raw | waw) & !flush;
   assign issue = id_valid & id_wr & (id_rd != '0) & !flush & !stall_all & !hz;
   assign stall_if = stall_all | hz;
   assign stall_pd = stall_all | hz;
   assign stall_id = stall_all | hz;
   assign stall_ex = stall_all;
   assign stall_mem = stall_all;
   assign bubble_ex = hz & !stall_all;
   // a fresh issue overrides the decrement of its own entry
   always_comb begin
      for (int i = 0; i < NREG; i++)
         sb_d[i] = (sb_q[i] != '0 && !stall_all) ? sb_q[i] - CW'(1) : sb_q[i];
      sb_d[0] = '0;
      if (issue && lat_c != '0) sb_d[id_rd] = lat_c;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb_q <= '{default: '0};
      else sb_q <= sb_d;
   end
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else if (hz && !stall_all) perf_q <= perf_q + 32'd1;
   end
   assign perf_hz_cnt = perf_q;
`else
   assign perf_hz_cnt = '0;
`endif
endmodule
